// File: rtl/instruction_bus_pkg.sv
// rtl/instruction_bus_pkg.sv - shared constants and types for the instruction BRAM bus
package instruction_bus_pkg;

  localparam int INSTR_OP_SIZE      = 8;
  localparam int INSTR_READ_LATENCY = 2;
  localparam int INSTR_NUM_READERS  = 2;

  // Read-return pipe entry at the default reader count. Modules with a
  // different reader count declare their own parameter-sized copy.
  typedef struct packed {
    logic                         valid;
    logic [INSTR_NUM_READERS-1:0] owner;
  } pipe_entry_t;

  // Pointer width that stays legal for a single requester.
  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/instruction_bram_arbiter_rr_arbiter.sv
// rtl/instruction_bram_arbiter_rr_arbiter.sv - round-robin grant over the fetch readers
//
// Ports:
//   clk_in, rst_in : clock, asynchronous active-high reset
//   req            : per-reader request vector
//   advance        : a read is being issued this cycle; move the pointer
//   grant          : one-hot grant (combinational), zero when nothing requests
module rr_arbiter
  import instruction_bus_pkg::*;
#(
  parameter int NUM_READERS = INSTR_NUM_READERS
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic [NUM_READERS-1:0] req,
  input  logic                   advance,
  output logic [NUM_READERS-1:0] grant
);

  localparam int PTR_W = ptr_width(NUM_READERS);

  logic [PTR_W-1:0] ptr;
  logic [PTR_W-1:0] gnt_idx;
  logic             found;

  // Search starts one past the last served reader so every requester is
  // reached within NUM_READERS read grants. With one reader this reduces to
  // grant = req.
  always_comb begin
    grant   = '0;
    gnt_idx = ptr;
    found   = 1'b0;
    for (int k = 1; k <= NUM_READERS; k++) begin
      if (!found && req[(int'(ptr) + k) % NUM_READERS]) begin
        found                                   = 1'b1;
        grant[(int'(ptr) + k) % NUM_READERS]    = 1'b1;
        gnt_idx = PTR_W'((int'(ptr) + k) % NUM_READERS);
      end
    end
  end

  // Reset to the last index so reader0 is first after reset.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      ptr <= PTR_W'(NUM_READERS - 1);
    end else if (advance && found) begin
      ptr <= gnt_idx;
    end
  end

endmodule

// File: rtl/instruction_bram_arbiter.sv
// rtl/instruction_bram_arbiter.sv - shares one single-port instruction BRAM between fetch readers and a program-load writer
//
// Ports:
//   clk_in, rst_in      : clock, asynchronous active-high reset
//   rd_valid_in         : per-reader read request
//   rd_addr_in          : packed read addresses, reader i at [i*ADDR_SIZE +: ADDR_SIZE]
//   rd_ready_out        : one-hot read grant
//   rd_data_out         : shared read-return data
//   rd_resp_valid_out   : one-hot owner of rd_data_out this cycle
//   wr_valid_in/addr/data, wr_ready_out : program-load write port
//   bram_addr/din/we/regce, bram_dout   : BRAM interface
module instruction_bram_arbiter
  import instruction_bus_pkg::*;
#(
  parameter int  ADDRS        = 256,
  parameter int  OP_SIZE      = INSTR_OP_SIZE,
  parameter int  NUM_READERS  = INSTR_NUM_READERS,
  parameter int  READ_LATENCY = INSTR_READ_LATENCY,
  parameter int  MAX_WR_BURST = 4,
  localparam int ADDR_SIZE    = $clog2(ADDRS)
) (
  input  logic                             clk_in,
  input  logic                             rst_in,
  input  logic [NUM_READERS-1:0]           rd_valid_in,
  input  logic [NUM_READERS*ADDR_SIZE-1:0] rd_addr_in,
  output logic [NUM_READERS-1:0]           rd_ready_out,
  output logic [OP_SIZE-1:0]               rd_data_out,
  output logic [NUM_READERS-1:0]           rd_resp_valid_out,
  input  logic                             wr_valid_in,
  input  logic [ADDR_SIZE-1:0]             wr_addr_in,
  input  logic [OP_SIZE-1:0]               wr_data_in,
  output logic                             wr_ready_out,
  output logic [ADDR_SIZE-1:0]             bram_addr,
  output logic [OP_SIZE-1:0]               bram_din,
  output logic                             bram_we,
  output logic                             bram_regce,
  input  logic [OP_SIZE-1:0]               bram_dout
);

  localparam int CNT_W = $clog2(MAX_WR_BURST + 1);

  typedef struct packed {
    logic                   valid;
    logic [NUM_READERS-1:0] owner;
  } rd_pipe_entry_t;

  logic                   any_rd;
  logic                   wr_grant;
  logic                   rd_grant;
  logic [NUM_READERS-1:0] rr_grant;
  logic [CNT_W-1:0]       burst_cnt;
  logic [ADDR_SIZE-1:0]   last_addr;
  logic [ADDR_SIZE-1:0]   rd_sel_addr;
  rd_pipe_entry_t         pipe [READ_LATENCY];
  rd_pipe_entry_t         pipe_out;

  assign any_rd = |rd_valid_in;

  // Writes win unless they have already taken MAX_WR_BURST grants in a row
  // while a reader waits. Grants are masked during reset so a write that
  // lines up with reset never reaches the BRAM.
  assign wr_grant = !rst_in && wr_valid_in &&
                    ((burst_cnt < CNT_W'(MAX_WR_BURST)) || !any_rd);
  assign rd_grant = !rst_in && !wr_grant && any_rd;

  rr_arbiter #(
    .NUM_READERS(NUM_READERS)
  ) u_rr (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .req    (rd_valid_in),
    .advance(rd_grant),
    .grant  (rr_grant)
  );

  always_comb begin
    rd_sel_addr = '0;
    for (int i = 0; i < NUM_READERS; i++) begin
      if (rr_grant[i]) begin
        rd_sel_addr = rd_addr_in[i*ADDR_SIZE +: ADDR_SIZE];
      end
    end
  end

  assign rd_ready_out = rd_grant ? rr_grant : '0;
  assign wr_ready_out = wr_grant;
  assign bram_we      = wr_grant;
  assign bram_din     = rst_in ? '0 : wr_data_in;
  assign bram_regce   = 1'b1;

  // Idle cycles keep the last issued address on the BRAM to avoid needless
  // address toggling.
  always_comb begin
    bram_addr = last_addr;
    if (wr_grant) begin
      bram_addr = wr_addr_in;
    end else if (rd_grant) begin
      bram_addr = rd_sel_addr;
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      last_addr <= '0;
    end else if (wr_grant || rd_grant) begin
      last_addr <= bram_addr;
    end
  end

  // Burst counter saturates; any read grant or an idle write port restarts it.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      burst_cnt <= '0;
    end else if (rd_grant || !wr_valid_in) begin
      burst_cnt <= '0;
    end else if (wr_grant && (burst_cnt < CNT_W'(MAX_WR_BURST))) begin
      burst_cnt <= burst_cnt + CNT_W'(1);
    end
  end

  // Response tag pipe mirrors the BRAM read latency so the tag at the tail
  // lines up with bram_dout for the same issue cycle.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      for (int i = 0; i < READ_LATENCY; i++) begin
        pipe[i] <= '0;
      end
    end else begin
      pipe[0] <= '{valid: rd_grant, owner: rd_ready_out};
      for (int i = 1; i < READ_LATENCY; i++) begin
        pipe[i] <= pipe[i-1];
      end
    end
  end

  assign pipe_out          = pipe[READ_LATENCY-1];
  assign rd_resp_valid_out = pipe_out.valid ? pipe_out.owner : '0;
  assign rd_data_out       = pipe_out.valid ? bram_dout : '0;

endmodule

// File: tb/tb_instruction_bram_arbiter.sv
// tb/tb_instruction_bram_arbiter.sv - self-checking bench for instruction_bram_arbiter
module tb_instruction_bram_arbiter;

  localparam int AW = 8;
  localparam int DW = 8;
  localparam int NR = 2;

  logic          clk_in = 1'b0;
  logic          rst_in;
  logic [NR-1:0] rd_valid_in;
  logic [NR*AW-1:0] rd_addr_in;
  logic [NR-1:0] rd_ready_out;
  logic [DW-1:0] rd_data_out;
  logic [NR-1:0] rd_resp_valid_out;
  logic          wr_valid_in;
  logic [AW-1:0] wr_addr_in;
  logic [DW-1:0] wr_data_in;
  logic          wr_ready_out;
  logic [AW-1:0] bram_addr;
  logic [DW-1:0] bram_din;
  logic          bram_we;
  logic          bram_regce;
  logic [DW-1:0] bram_dout;

  int checks   = 0;
  int failures = 0;

  always #5 clk_in = ~clk_in;

  instruction_bram_arbiter dut (
    .clk_in           (clk_in),
    .rst_in           (rst_in),
    .rd_valid_in      (rd_valid_in),
    .rd_addr_in       (rd_addr_in),
    .rd_ready_out     (rd_ready_out),
    .rd_data_out      (rd_data_out),
    .rd_resp_valid_out(rd_resp_valid_out),
    .wr_valid_in      (wr_valid_in),
    .wr_addr_in       (wr_addr_in),
    .wr_data_in       (wr_data_in),
    .wr_ready_out     (wr_ready_out),
    .bram_addr        (bram_addr),
    .bram_din         (bram_din),
    .bram_we          (bram_we),
    .bram_regce       (bram_regce),
    .bram_dout        (bram_dout)
  );

  // Initial BRAM contents: mem[a] = a*7 + 0x35, so mem[0x10] = 0xA5.
  function automatic logic [DW-1:0] init_val(input int a);
    return DW'((a * 7 + 'h35) & 'hFF);
  endfunction

  // BRAM model: two-cycle registered read, written words tracked by flag.
  logic [DW-1:0] mem [256];
  logic [255:0]  written;
  logic          mem_clr;
  logic [DW-1:0] rd_q1;

  always @(posedge clk_in) begin
    if (mem_clr) begin
      written <= '0;
    end else if (bram_we) begin
      mem[bram_addr]     <= bram_din;
      written[bram_addr] <= 1'b1;
    end
    rd_q1     <= written[bram_addr] ? mem[bram_addr] : init_val(int'(bram_addr));
    bram_dout <= rd_q1;
  end

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic idle_inputs();
    rd_valid_in = '0;
    rd_addr_in  = '0;
    wr_valid_in = 1'b0;
    wr_addr_in  = '0;
    wr_data_in  = '0;
  endtask

  task automatic apply_reset();
    idle_inputs();
    rst_in = 1'b1;
    tick();
    tick();
    rst_in = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rd_valid_in = 2'b11;
    rd_addr_in  = {8'h33, 8'h44};
    wr_valid_in = 1'b1;
    wr_addr_in  = 8'h55;
    wr_data_in  = 8'h66;
    rst_in      = 1'b1;
    @(negedge clk_in);
    checks++;
    if (rd_ready_out !== 2'b00 || wr_ready_out !== 1'b0 || bram_we !== 1'b0) begin
      failures++;
      $display("FAIL reset_grants rd_ready=%b wr_ready=%b we=%b required 00 0 0", rd_ready_out, wr_ready_out, bram_we);
    end
    checks++;
    if (bram_addr !== 8'h00 || bram_din !== 8'h00 || rd_data_out !== 8'h00 || rd_resp_valid_out !== 2'b00) begin
      failures++;
      $display("FAIL reset_bus addr=%h din=%h data=%h resp=%b required 00 00 00 00", bram_addr, bram_din, rd_data_out, rd_resp_valid_out);
    end
    checks++;
    if (bram_regce !== 1'b1) begin
      failures++;
      $display("FAIL reset_regce got=%b required 1", bram_regce);
    end
    apply_reset();
  endtask

  task automatic test_single_read();
    idle_inputs();
    tick();
    rd_valid_in = 2'b01;
    rd_addr_in  = {8'h00, 8'h10};
    @(negedge clk_in);
    checks++;
    if (rd_ready_out !== 2'b01 || bram_addr !== 8'h10 || bram_we !== 1'b0) begin
      failures++;
      $display("FAIL single_grant rd_ready=%b addr=%h we=%b required 01 10 0", rd_ready_out, bram_addr, bram_we);
    end
    tick();
    idle_inputs();
    @(negedge clk_in);
    checks++;
    if (rd_resp_valid_out !== 2'b00) begin
      failures++;
      $display("FAIL single_early_resp got=%b required 00", rd_resp_valid_out);
    end
    tick();
    @(negedge clk_in);
    checks++;
    if (rd_resp_valid_out !== 2'b01 || rd_data_out !== 8'hA5) begin
      failures++;
      $display("FAIL single_resp valid=%b data=%h required 01 a5", rd_resp_valid_out, rd_data_out);
    end
    checks++;
    if (bram_addr !== 8'h10) begin
      failures++;
      $display("FAIL idle_addr_hold got=%h required 10", bram_addr);
    end
    tick();
    @(negedge clk_in);
    checks++;
    if (rd_resp_valid_out !== 2'b00) begin
      failures++;
      $display("FAIL single_late_resp got=%b required 00", rd_resp_valid_out);
    end
  endtask

  task automatic test_round_robin();
    logic [NR-1:0] exp_owner [8];
    logic [AW-1:0] exp_addr  [8];
    apply_reset();
    for (int k = 0; k < 8; k++) begin
      if (k < 6) begin
        rd_valid_in = 2'b11;
        rd_addr_in  = {AW'(8'h80 + k), AW'(8'h40 + k)};
        exp_owner[k] = (k % 2 == 0) ? 2'b01 : 2'b10;
        exp_addr[k]  = (k % 2 == 0) ? AW'(8'h40 + k) : AW'(8'h80 + k);
      end else begin
        rd_valid_in = 2'b00;
      end
      @(negedge clk_in);
      if (k < 6) begin
        checks++;
        if (rd_ready_out !== exp_owner[k]) begin
          failures++;
          $display("FAIL rr_grant k=%0d got=%b required %b", k, rd_ready_out, exp_owner[k]);
        end
      end
      if (k >= 2) begin
        checks++;
        if (rd_resp_valid_out !== exp_owner[k-2] || rd_data_out !== init_val(int'(exp_addr[k-2]))) begin
          failures++;
          $display("FAIL rr_resp k=%0d valid=%b data=%h required %b %h", k, rd_resp_valid_out, rd_data_out, exp_owner[k-2], init_val(int'(exp_addr[k-2])));
        end
      end
      tick();
    end
    idle_inputs();
  endtask

  task automatic test_back_to_back();
    idle_inputs();
    tick();
    for (int k = 0; k < 10; k++) begin
      if (k < 8) begin
        rd_valid_in = 2'b10;
        rd_addr_in  = {AW'(k), 8'hEE};
      end else begin
        rd_valid_in = 2'b00;
      end
      @(negedge clk_in);
      if (k < 8) begin
        checks++;
        if (rd_ready_out !== 2'b10 || bram_addr !== AW'(k)) begin
          failures++;
          $display("FAIL b2b_grant k=%0d rd_ready=%b addr=%h required 10 %h", k, rd_ready_out, bram_addr, AW'(k));
        end
      end
      if (k >= 2) begin
        checks++;
        if (rd_resp_valid_out !== 2'b10 || rd_data_out !== init_val(k - 2)) begin
          failures++;
          $display("FAIL b2b_resp k=%0d valid=%b data=%h required 10 %h", k, rd_resp_valid_out, rd_data_out, init_val(k - 2));
        end
      end
      tick();
    end
    idle_inputs();
  endtask

  task automatic test_write_burst();
    logic exp_wr;
    idle_inputs();
    tick();
    // Reader1 contends: W W W W R W W W W R
    for (int k = 0; k < 10; k++) begin
      wr_valid_in = 1'b1;
      wr_addr_in  = AW'(8'hC0 + k);
      wr_data_in  = DW'(8'h90 + k);
      rd_valid_in = 2'b10;
      rd_addr_in  = {8'h05, 8'h00};
      exp_wr = (k != 4) && (k != 9);
      @(negedge clk_in);
      checks++;
      if (wr_ready_out !== exp_wr || bram_we !== exp_wr || rd_ready_out !== (exp_wr ? 2'b00 : 2'b10)) begin
        failures++;
        $display("FAIL burst_cap k=%0d wr_ready=%b we=%b rd_ready=%b required %b %b %b", k, wr_ready_out, bram_we, rd_ready_out, exp_wr, exp_wr, exp_wr ? 2'b00 : 2'b10);
      end
      tick();
    end
    idle_inputs();
    tick();
    tick();
    // No reader: all ten writes granted.
    for (int k = 0; k < 10; k++) begin
      wr_valid_in = 1'b1;
      wr_addr_in  = AW'(8'hD0 + k);
      wr_data_in  = DW'(8'h10 + k);
      @(negedge clk_in);
      checks++;
      if (wr_ready_out !== 1'b1 || bram_we !== 1'b1 || bram_addr !== AW'(8'hD0 + k) || bram_din !== DW'(8'h10 + k)) begin
        failures++;
        $display("FAIL burst_free k=%0d wr_ready=%b we=%b addr=%h din=%h required 1 1 %h %h", k, wr_ready_out, bram_we, bram_addr, bram_din, AW'(8'hD0 + k), DW'(8'h10 + k));
      end
      tick();
    end
    idle_inputs();
  endtask

  task automatic test_read_after_write();
    idle_inputs();
    tick();
    wr_valid_in = 1'b1;
    wr_addr_in  = 8'h20;
    wr_data_in  = 8'h3C;
    @(negedge clk_in);
    checks++;
    if (wr_ready_out !== 1'b1) begin
      failures++;
      $display("FAIL raw_write_grant got=%b required 1", wr_ready_out);
    end
    tick();
    idle_inputs();
    rd_valid_in = 2'b01;
    rd_addr_in  = {8'h00, 8'h20};
    @(negedge clk_in);
    checks++;
    if (rd_ready_out !== 2'b01) begin
      failures++;
      $display("FAIL raw_read_grant got=%b required 01", rd_ready_out);
    end
    tick();
    idle_inputs();
    tick();
    @(negedge clk_in);
    checks++;
    if (rd_resp_valid_out !== 2'b01 || rd_data_out !== 8'h3C) begin
      failures++;
      $display("FAIL raw_resp valid=%b data=%h required 01 3c", rd_resp_valid_out, rd_data_out);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    idle_inputs();
    tick();
    rd_valid_in = 2'b01;
    rd_addr_in  = {8'h00, 8'h11};
    @(negedge clk_in);
    checks++;
    if (rd_ready_out !== 2'b01) begin
      failures++;
      $display("FAIL rstmid_grant got=%b required 01", rd_ready_out);
    end
    tick();
    rst_in      = 1'b1;
    wr_valid_in = 1'b1;
    wr_addr_in  = 8'h11;
    wr_data_in  = 8'hFF;
    @(negedge clk_in);
    checks++;
    if (rd_ready_out !== 2'b00 || wr_ready_out !== 1'b0 || bram_we !== 1'b0 || rd_resp_valid_out !== 2'b00 || bram_addr !== 8'h00) begin
      failures++;
      $display("FAIL rstmid_outputs rd_ready=%b wr_ready=%b we=%b resp=%b addr=%h required 00 0 0 00 00", rd_ready_out, wr_ready_out, bram_we, rd_resp_valid_out, bram_addr);
    end
    tick();
    rst_in = 1'b0;
    idle_inputs();
    @(negedge clk_in);
    checks++;
    if (rd_resp_valid_out !== 2'b00) begin
      failures++;
      $display("FAIL rstmid_no_resp got=%b required 00", rd_resp_valid_out);
    end
    tick();
    rd_valid_in = 2'b01;
    rd_addr_in  = {8'h00, 8'h11};
    @(negedge clk_in);
    checks++;
    if (rd_ready_out !== 2'b01 || rd_resp_valid_out !== 2'b00) begin
      failures++;
      $display("FAIL rstmid_resume_grant rd_ready=%b resp=%b required 01 00", rd_ready_out, rd_resp_valid_out);
    end
    tick();
    idle_inputs();
    tick();
    @(negedge clk_in);
    checks++;
    if (rd_resp_valid_out !== 2'b01 || rd_data_out !== init_val('h11)) begin
      failures++;
      $display("FAIL rstmid_resume_resp valid=%b data=%h required 01 %h", rd_resp_valid_out, rd_data_out, init_val('h11));
    end
    tick();
  endtask

  initial begin
    idle_inputs();
    rst_in  = 1'b1;
    mem_clr = 1'b1;
    tick();
    mem_clr = 1'b0;
    test_reset();
    test_single_read();
    test_round_robin();
    test_back_to_back();
    test_write_burst();
    test_read_after_write();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
